lock_key_loader: RTL and testbench
==================================

LOCK_KEY_LOADER -- requirements
Module: lock_key_loader

Interface
REQ-001 SHALL have parameter KEY_W, default 64, meaning key width in bits.
REQ-002 SHALL have parameter OP_W, default 32, meaning operand width in bits; the sum is OP_W+1 bits.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port key_load_start_i  in  1  request to begin a new serial key load.
REQ-006 SHALL have port key_bit_i  in  1  serial key data bit, LSB first.
REQ-007 SHALL have port key_bit_valid_i  in  1  key_bit_i is valid this cycle.
REQ-008 SHALL have port key_ready_o  out  1  a complete key is installed.
REQ-009 SHALL have port keyinput  out  KEY_W  key driven to the locked adder.
REQ-010 SHALL have port op_valid_i  in  1  operand pair valid.
REQ-011 SHALL have port op_ready_o  out  1  operand pair accepted when both valid and ready are high.
REQ-012 SHALL have port op_a_i, op_b_i  in  OP_W  operands.
REQ-013 SHALL have ports add1_i, add2_i  out  OP_W  registered operands to the locked adder.
REQ-014 SHALL have port result_o  in  OP_W+1  combinational sum returned from the locked adder.
REQ-015 SHALL have port sum_o  out  OP_W+1  captured sum.
REQ-016 SHALL have ports sum_valid_o  out  1  and sum_ready_i  in  1, forming the result handshake.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD and READY.
REQ-018 FSM transitions SHALL be: IDLE->LOAD on start; LOAD->READY on acceptance of the KEY_W-th bit; READY->LOAD on start when stage-1 is empty.
REQ-019 In READY, a start SHALL be ignored while stage-1 holds data; the start is not queued.
REQ-020 A start received in LOAD SHALL restart the bit counter at 0 and discard the partially loaded shadow register.
REQ-021 In LOAD, each cycle with key_bit_valid_i=1 SHALL write key_bit_i into shadow[cnt] and increment cnt.
REQ-022 The counter SHALL be ceil(log2(KEY_W)) bits wide and SHALL wrap to 0 after KEY_W-1.
REQ-023 key_bit_valid_i SHALL be ignored outside LOAD.
REQ-024 On the cycle the final bit is accepted, shadow (including that bit) SHALL be copied to keyinput and key_ready_o SHALL rise the next cycle.
REQ-025 keyinput SHALL be all-zero whenever the state is not READY; a partial key is never exposed.
REQ-026 key_ready_o SHALL be 1 only in READY.
REQ-027 The operand pipeline SHALL have two stages: s1 holds add1_i/add2_i; s2 captures result_o into sum_o.
REQ-028 Define adv = !s2_valid || sum_ready_i.
REQ-029 s2 SHALL load result_o and s1_valid when adv=1, and SHALL hold otherwise.
REQ-030 s1 SHALL load the operands when op_valid_i && op_ready_o, SHALL clear when it advances without a new accept, and SHALL hold otherwise.
REQ-031 op_ready_o SHALL equal key_ready_o && (!s1_valid || adv).
REQ-032 Latency from accept to sum_valid_o SHALL be 2 cycles with no backpressure; throughput SHALL be 1 operation per cycle.
REQ-033 Under sum_ready_i=0, sum_o and sum_valid_o SHALL hold stable and no data SHALL be lost or duplicated.
REQ-034 Leaving READY SHALL NOT flush s2; a pending sum drains normally.
REQ-035 add1_i/add2_i SHALL hold their last values when s1 is empty.

Reset
REQ-036 rst SHALL force state=IDLE, cnt=0, shadow=0, keyinput=0, key_ready_o=0, s1_valid=0, s2_valid=0, add1_i=0, add2_i=0 and sum_o=0 immediately, without waiting for a clock edge.
REQ-037 Reset asserted mid-load or mid-pipeline SHALL discard all state; after release, a full new key load is required.

Structure
REQ-038 KEY_W, OP_W and the FSM state enumeration SHALL live in the shared package lock_pkg.
REQ-039 The s1/s2 valid-ready pipeline SHALL be one sub-module, lock_op_pipe; the FSM and shift logic SHALL stay in the top level.

Verification
REQ-040 Scenario: reset, start, then 64 valid bits forming 0xA5A5_0000_FFFF_1234 -> keyinput=0xA5A50000FFFF1234 and key_ready_o=1 exactly one cycle after the 64th bit; keyinput=0 throughout the load.
REQ-041 Scenario: 20 bits loaded, then start again, then 64 bits -> the key equals only the last 64 bits.
REQ-042 Scenario: key ready, op_a=0xFFFFFFFF, op_b=0x00000001, result_o modeled as correct add -> sum_o=0x1_0000_0000, sum_valid_o 2 cycles after accept.
REQ-043 Scenario: back-to-back 8 operations with sum_ready_i low for cycles 3-6 -> 8 sums in order, no drop or duplicate, op_ready_o low while s1 and s2 are full.
REQ-044 Scenario: rst asserted between clock edges mid-load (bit 40) and mid-pipeline -> all outputs 0 asynchronously; op_ready_o=0 until a new full load completes.
REQ-045 Scenario: start in READY with s1 valid -> ignored, state stays READY; start repeated once s1 is empty -> LOAD and keyinput=0.

Source files
------------

// File: rtl/lock_pkg.sv
// ----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the lock key loader slice: default key/operand
// widths, the key-load FSM state encoding and a counter-width helper.
// ----------------------------------------------------------------------------
package lock_pkg;

   localparam int KEY_W = 64;   // key width in bits
   localparam int OP_W  = 32;   // operand width in bits (sum is OP_W+1)

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } key_state_e;

   // Bit counter width: ceil(log2(w)), never below one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/lock_key_loader_if.sv
// ----------------------------------------------------------------------------
// lock_key_loader_if
// Operand/result handshake bundle of the lock key loader.
//   op_valid_i / op_ready_o  : operand pair handshake
//   op_a_i, op_b_i           : operands (OP_W bits)
//   sum_valid_o / sum_ready_i: result handshake
//   sum_o                    : captured sum (OP_W+1 bits)
// master = operand producer / result consumer, slave = the loader.
// ----------------------------------------------------------------------------
interface lock_key_loader_if #(
   parameter int OP_W = lock_pkg::OP_W
);

   logic            op_valid_i;
   logic            op_ready_o;
   logic [OP_W-1:0] op_a_i;
   logic [OP_W-1:0] op_b_i;
   logic [OP_W:0]   sum_o;
   logic            sum_valid_o;
   logic            sum_ready_i;

   modport master (
      output op_valid_i, op_a_i, op_b_i, sum_ready_i,
      input  op_ready_o, sum_o, sum_valid_o
   );

   modport slave (
      input  op_valid_i, op_a_i, op_b_i, sum_ready_i,
      output op_ready_o, sum_o, sum_valid_o
   );

endinterface

// File: rtl/lock_op_pipe.sv
// ----------------------------------------------------------------------------
// lock_op_pipe
// Two-stage valid/ready operand pipeline around the external locked adder.
//   s1: registered operands add1_i/add2_i (driven to the adder)
//   s2: captures the adder's combinational result_o into sum_o
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : operands may be accepted only while a key is installed
//   bus        : operand/result handshake (slave side)
//   add1_i/2_i : operands to the locked adder
//   result_o   : sum returned from the locked adder
//   s1_valid   : stage-1 occupancy, used by the key FSM to gate restarts
// ----------------------------------------------------------------------------
module lock_op_pipe #(
   parameter int OP_W = lock_pkg::OP_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   lock_key_loader_if.slave bus,
   output logic [OP_W-1:0] add1_i,
   output logic [OP_W-1:0] add2_i,
   input  logic [OP_W:0]   result_o,
   output logic            s1_valid
);

   logic s2_valid;
   logic adv;
   logic accept;

   // s2 can take new data when it is empty or being drained this cycle.
   assign adv             = !s2_valid || bus.sum_ready_i;
   assign bus.op_ready_o  = enable && (!s1_valid || adv);
   assign accept          = bus.op_valid_i && bus.op_ready_o;
   assign bus.sum_valid_o = s2_valid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         add1_i    <= '0;
         add2_i    <= '0;
         bus.sum_o <= '0;
      end else begin
         if (adv) begin
            s2_valid  <= s1_valid;
            bus.sum_o <= result_o;
         end
         // Operands are left untouched when s1 empties so the adder inputs
         // do not toggle needlessly.
         if (accept) begin
            s1_valid <= 1'b1;
            add1_i   <= bus.op_a_i;
            add2_i   <= bus.op_b_i;
         end else if (adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/lock_key_loader.sv
// ----------------------------------------------------------------------------
// lock_key_loader
// Serially loads a KEY_W-bit key (LSB first) into a shadow register and, once
// complete, installs it on keyinput for a logic-locked adder. Operand pairs
// are then streamed through a two-stage pipeline to that adder.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   key_load_start_i    : begin (or restart) a serial key load
//   key_bit_i           : serial key bit, LSB first
//   key_bit_valid_i     : key_bit_i valid this cycle
//   key_ready_o         : a complete key is installed
//   keyinput            : key to the locked adder (zero unless installed)
//   op_bus              : operand/result handshake (slave side)
//   add1_i, add2_i      : registered operands to the locked adder
//   result_o            : combinational sum from the locked adder
// ----------------------------------------------------------------------------
module lock_key_loader #(
   parameter int KEY_W = lock_pkg::KEY_W,
   parameter int OP_W  = lock_pkg::OP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_load_start_i,
   input  logic             key_bit_i,
   input  logic             key_bit_valid_i,
   output logic             key_ready_o,
   output logic [KEY_W-1:0] keyinput,
   lock_key_loader_if.slave op_bus,
   output logic [OP_W-1:0]  add1_i,
   output logic [OP_W-1:0]  add2_i,
   input  logic [OP_W:0]    result_o
);

   import lock_pkg::key_state_e;
   import lock_pkg::IDLE;
   import lock_pkg::LOAD;
   import lock_pkg::READY;
   import lock_pkg::cnt_width;

   localparam int               CNT_W    = cnt_width(KEY_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);

   key_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [KEY_W-1:0] shadow;
   logic [KEY_W-1:0] shadow_nxt;
   logic             s1_valid;

   // Shadow with the current serial bit merged in; lets the final bit land
   // in keyinput on the same edge that accepts it.
   // NOTE: give every always_comb output a default first so no path leaves
   // it unassigned and a latch is inferred.
   always_comb begin
      shadow_nxt      = shadow;
      shadow_nxt[cnt] = key_bit_i;
   end

   // NOTE: the shadow is a plain register, not a RAM, so it is reset like any
   // other state; a stale partial key must never survive reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         shadow      <= '0;
         keyinput    <= '0;
         key_ready_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (key_load_start_i) begin
                  state  <= LOAD;
                  cnt    <= '0;
                  shadow <= '0;
               end
            end
            LOAD: begin
               // A restart has priority over a bit arriving the same cycle.
               if (key_load_start_i) begin
                  cnt    <= '0;
                  shadow <= '0;
               end else if (key_bit_valid_i) begin
                  shadow <= shadow_nxt;
                  if (cnt == CNT_LAST) begin
                     cnt         <= '0;
                     keyinput    <= shadow_nxt;
                     key_ready_o <= 1'b1;
                     state       <= READY;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            READY: begin
               // Restart only once stage 1 is empty; otherwise drop the start.
               if (key_load_start_i && !s1_valid) begin
                  state       <= LOAD;
                  cnt         <= '0;
                  shadow      <= '0;
                  keyinput    <= '0;
                  key_ready_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   lock_op_pipe #(.OP_W(OP_W)) u_op_pipe (
      .clk      (clk),
      .rst      (rst),
      .enable   (key_ready_o),
      .bus      (op_bus),
      .add1_i   (add1_i),
      .add2_i   (add2_i),
      .result_o (result_o),
      .s1_valid (s1_valid)
   );

endmodule

// File: tb/tb_lock_key_loader.sv
// ----------------------------------------------------------------------------
// tb_lock_key_loader
// Directed self-checking bench for lock_key_loader. The locked adder is
// modelled as a correct OP_W-bit add. Inputs are driven and outputs sampled
// on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_lock_key_loader;

   localparam int KEY_W = 64;
   localparam int OP_W  = 32;

   localparam logic [63:0] K1 = 64'hA5A5_0000_FFFF_1234;
   localparam logic [63:0] K2 = 64'h0123_4567_89AB_CDEF;

   logic             clk;
   logic             rst;
   logic             key_load_start_i;
   logic             key_bit_i;
   logic             key_bit_valid_i;
   logic             key_ready_o;
   logic [KEY_W-1:0] keyinput;
   logic [OP_W-1:0]  add1_i;
   logic [OP_W-1:0]  add2_i;
   logic [OP_W:0]    result_o;

   int n_checks = 0;
   int n_fail   = 0;

   lock_key_loader_if #(.OP_W(OP_W)) bus ();

   lock_key_loader #(.KEY_W(KEY_W), .OP_W(OP_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .key_load_start_i (key_load_start_i),
      .key_bit_i        (key_bit_i),
      .key_bit_valid_i  (key_bit_valid_i),
      .key_ready_o      (key_ready_o),
      .keyinput         (keyinput),
      .op_bus           (bus),
      .add1_i           (add1_i),
      .add2_i           (add2_i),
      .result_o         (result_o)
   );

   // Correct (unlocked) adder behaviour.
   assign result_o = {1'b0, add1_i} + {1'b0, add2_i};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Start pulse then KEY_W valid bits, LSB first. leak flags any cycle in
   // which key_ready_o or keyinput was non-zero before the final edge.
   task automatic load_key(input logic [63:0] k, output logic leak);
      leak = 1'b0;
      key_load_start_i = 1'b1;
      step();
      key_load_start_i = 1'b0;
      for (int i = 0; i < KEY_W; i++) begin
         key_bit_i       = k[i];
         key_bit_valid_i = 1'b1;
         leak = leak | key_ready_o | (|keyinput);
         step();
      end
      key_bit_valid_i = 1'b0;
      key_bit_i       = 1'b0;
   endtask

   function automatic logic [OP_W-1:0] op_a(input int i);
      return 32'hFFFF_FFF0 + OP_W'(i);
   endfunction

   function automatic logic [OP_W-1:0] op_b(input int i);
      return OP_W'(i) * 32'h0101_0101;
   endfunction

   function automatic logic [OP_W:0] op_sum(input int i);
      return {1'b0, op_a(i)} + {1'b0, op_b(i)};
   endfunction

   initial begin
      logic        leak;
      logic [11:0] exp_rdy;
      int          issued;
      int          got;

      rst              = 1'b1;
      key_load_start_i = 1'b0;
      key_bit_i        = 1'b0;
      key_bit_valid_i  = 1'b0;
      bus.op_valid_i   = 1'b0;
      bus.op_a_i       = '0;
      bus.op_b_i       = '0;
      bus.sum_ready_i  = 1'b1;
      step();
      step();

      // Reset state
      check("rst_key_ready", key_ready_o, 0);
      check("rst_keyinput", keyinput, 0);
      check("rst_op_ready", bus.op_ready_o, 0);
      check("rst_sum_valid", bus.sum_valid_o, 0);
      check("rst_sum", bus.sum_o, 0);
      rst = 1'b0;
      step();

      // Full key load
      load_key(K1, leak);
      check("load1_no_partial_key", leak, 0);
      check("load1_key_ready", key_ready_o, 1);
      check("load1_keyinput", keyinput, K1);

      // Single add with carry out, 2-cycle latency
      bus.op_valid_i = 1'b1;
      bus.op_a_i     = 32'hFFFF_FFFF;
      bus.op_b_i     = 32'h0000_0001;
      #1;
      check("add_op_ready", bus.op_ready_o, 1);
      step();
      bus.op_valid_i = 1'b0;
      check("add_lat1_sum_valid", bus.sum_valid_o, 0);
      check("add_add1", add1_i, 32'hFFFF_FFFF);
      check("add_add2", add2_i, 32'h0000_0001);
      step();
      check("add_lat2_sum_valid", bus.sum_valid_o, 1);
      check("add_sum", bus.sum_o, 33'h1_0000_0000);
      step();
      check("add_drained", bus.sum_valid_o, 0);
      check("add_hold_add1", add1_i, 32'hFFFF_FFFF);

      // Start in READY while stage 1 is full is dropped
      bus.op_valid_i  = 1'b1;
      bus.op_a_i      = 32'd5;
      bus.op_b_i      = 32'd6;
      bus.sum_ready_i = 1'b0;
      step();
      bus.op_valid_i   = 1'b0;
      key_load_start_i = 1'b1;
      step();
      key_load_start_i = 1'b0;
      check("start_ignored_key_ready", key_ready_o, 1);
      check("start_ignored_keyinput", keyinput, K1);
      check("pend_sum_valid", bus.sum_valid_o, 1);
      check("pend_sum", bus.sum_o, 33'd11);
      // Stage 1 now empty: start is taken, pending sum survives
      key_load_start_i = 1'b1;
      step();
      key_load_start_i = 1'b0;
      check("restart_key_ready", key_ready_o, 0);
      check("restart_keyinput", keyinput, 0);
      check("restart_op_ready", bus.op_ready_o, 0);
      check("no_flush_sum_valid", bus.sum_valid_o, 1);
      check("no_flush_sum", bus.sum_o, 33'd11);
      bus.sum_ready_i = 1'b1;
      step();
      check("pend_drained", bus.sum_valid_o, 0);

      // Partial load of 20 ones, then restart and a full new key
      for (int i = 0; i < 20; i++) begin
         key_bit_i       = 1'b1;
         key_bit_valid_i = 1'b1;
         step();
      end
      key_bit_valid_i = 1'b0;
      check("partial_keyinput", keyinput, 0);
      load_key(K2, leak);
      check("load2_no_partial_key", leak, 0);
      check("load2_key_ready", key_ready_o, 1);
      check("load2_keyinput", keyinput, K2);

      // 8 back-to-back ops, sum_ready low in cycles 3..6
      exp_rdy = 12'b1111_1000_0111;
      issued  = 0;
      got     = 0;
      for (int c = 0; c < 16; c++) begin
         bus.sum_ready_i = !(c >= 3 && c <= 6);
         if (issued < 8) begin
            bus.op_valid_i = 1'b1;
            bus.op_a_i     = op_a(issued);
            bus.op_b_i     = op_b(issued);
         end else begin
            bus.op_valid_i = 1'b0;
         end
         #1;
         if (c < 12)
            check($sformatf("burst_op_ready_c%0d", c), bus.op_ready_o, exp_rdy[c]);
         if (c >= 3 && c <= 6) begin
            check($sformatf("stall_sum_valid_c%0d", c), bus.sum_valid_o, 1);
            check($sformatf("stall_sum_c%0d", c), bus.sum_o, op_sum(1));
         end
         if (bus.sum_valid_o && bus.sum_ready_i) begin
            if (got < 8)
               check($sformatf("burst_sum_%0d", got), bus.sum_o, op_sum(got));
            got++;
         end
         if (bus.op_valid_i && bus.op_ready_o)
            issued++;
         step();
      end
      bus.op_valid_i = 1'b0;
      check("burst_issued", issued, 8);
      check("burst_received", got, 8);

      // Async reset mid-pipeline (s1 and s2 both full)
      bus.sum_ready_i = 1'b0;
      bus.op_valid_i  = 1'b1;
      bus.op_a_i      = 32'd1;
      bus.op_b_i      = 32'd2;
      step();
      bus.op_a_i = 32'd3;
      bus.op_b_i = 32'd4;
      step();
      bus.op_valid_i = 1'b0;
      check("pre_rst_sum_valid", bus.sum_valid_o, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_pipe_sum_valid", bus.sum_valid_o, 0);
      check("arst_pipe_sum", bus.sum_o, 0);
      check("arst_pipe_add1", add1_i, 0);
      check("arst_pipe_add2", add2_i, 0);
      check("arst_pipe_key_ready", key_ready_o, 0);
      check("arst_pipe_keyinput", keyinput, 0);
      check("arst_pipe_op_ready", bus.op_ready_o, 0);
      @(negedge clk);
      rst             = 1'b0;
      bus.sum_ready_i = 1'b1;
      bus.op_valid_i  = 1'b1;
      step();
      step();
      step();
      check("post_rst_op_ready", bus.op_ready_o, 0);
      bus.op_valid_i = 1'b0;

      // Async reset mid-load at bit 40
      key_load_start_i = 1'b1;
      step();
      key_load_start_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         key_bit_i       = K1[i];
         key_bit_valid_i = 1'b1;
         step();
      end
      key_bit_valid_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_load_key_ready", key_ready_o, 0);
      check("arst_load_keyinput", keyinput, 0);
      @(negedge clk);
      rst = 1'b0;
      // Remaining 24 bits without a new start must not complete a key
      for (int i = 40; i < KEY_W; i++) begin
         key_bit_i       = K1[i];
         key_bit_valid_i = 1'b1;
         step();
      end
      key_bit_valid_i = 1'b0;
      check("resume_ignored_key_ready", key_ready_o, 0);
      check("resume_ignored_op_ready", bus.op_ready_o, 0);
      load_key(K1, leak);
      check("load3_no_partial_key", leak, 0);
      check("load3_key_ready", key_ready_o, 1);
      check("load3_keyinput", keyinput, K1);
      check("load3_op_ready", bus.op_ready_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
